// File: rtl/nse_pkg.sv
// Shared types for the netlist stream evaluator: gate opcodes, FSM states, fan-in limit.
package nse_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_NOT  = 3'd4,
        OP_BUF  = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } nse_state_e;

    localparam int MAX_FANIN = 3;

endpackage

// File: rtl/nse_gate_alu.sv
// Single-gate evaluator: reduces the used sources under the opcode and flags illegal records.
// Macro NSE_XOR_EN enables XOR/XNOR parity; without it those opcodes are illegal.
module nse_gate_alu
    import nse_pkg::*;
(
    input  gate_op_e                op,
    input  logic [1:0]              nin,
    input  logic [MAX_FANIN-1:0]    src,
    output logic                    res,
    output logic                    illegal
);

    logic [MAX_FANIN-1:0] used;
    logic and_r;
    logic or_r;
    logic xor_r;

    assign used  = (nin == 2'd3) ? 3'b111 :
                   (nin == 2'd2) ? 3'b011 :
                   (nin == 2'd1) ? 3'b001 : 3'b000;
    // Unused inputs become the identity element of each reduction.
    assign and_r = &(src | ~used);
    assign or_r  = |(src & used);
    assign xor_r = ^(src & used);

    always_comb begin
        res     = 1'b0;
        illegal = (nin == 2'd0);
        unique case (op)
            OP_AND:  res = and_r;
            OP_OR:   res = or_r;
            OP_NAND: res = ~and_r;
            OP_NOR:  res = ~or_r;
            OP_NOT: begin
                res = ~src[0];
                if (nin != 2'd1) illegal = 1'b1;
            end
            OP_BUF: begin
                res = src[0];
                if (nin != 2'd1) illegal = 1'b1;
            end
`ifdef NSE_XOR_EN
            OP_XOR:  res = xor_r;
            OP_XNOR: res = ~xor_r;
`else
            OP_XOR:  illegal = 1'b1;
            OP_XNOR: illegal = 1'b1;
`endif
        endcase
    end

`ifndef NSE_XOR_EN
    logic unused_xor;
    assign unused_xor = xor_r;
`endif

endmodule

// File: rtl/netlist_stream_eval.sv
// Streams gate records of one combinational netlist and evaluates every slot for one PI vector.
// Flags multi-driven, undriven and malformed records; XOR support follows NSE_XOR_EN.
module netlist_stream_eval
    import nse_pkg::*;
#(
    parameter int NUM_PI  = 10,
    parameter int NUM_SIG = 64,
    parameter int IDX_W   = 6,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_PI-1:0] pi_vec,
    input  logic              g_valid,
    output logic              g_ready,
    input  logic [2:0]        g_op,
    input  logic [1:0]        g_nin,
    input  logic [IDX_W-1:0]  g_dst,
    input  logic [IDX_W-1:0]  g_src0,
    input  logic [IDX_W-1:0]  g_src1,
    input  logic [IDX_W-1:0]  g_src2,
    input  logic              g_last,
    input  logic [IDX_W-1:0]  o_idx,
    output logic              o_val,
    output logic              done,
    output logic [CNT_W-1:0]  gate_cnt,
    output logic              err_multi,
    output logic              err_undrv,
    output logic              err_fmt
);

    nse_state_e state;
    nse_state_e state_nx;

    logic [NUM_SIG-1:0] val;
    logic [NUM_SIG-1:0] drv;

    logic [MAX_FANIN-1:0][IDX_W-1:0] srcs;
    logic [MAX_FANIN-1:0] used;
    logic [MAX_FANIN-1:0] src_bits;
    logic undrv;
    logic bad_idx;
    logic alu_res;
    logic alu_ill;
    logic fmt;
    logic multi;
    logic accept;

    function automatic logic oob(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} >= (IDX_W+1)'(NUM_SIG);
    endfunction

    assign srcs   = {g_src2, g_src1, g_src0};
    assign used   = (g_nin == 2'd3) ? 3'b111 :
                    (g_nin == 2'd2) ? 3'b011 :
                    (g_nin == 2'd1) ? 3'b001 : 3'b000;
    assign accept = g_valid && g_ready;
    assign o_val  = val[o_idx];

    // Undriven or out-of-range sources read as 0.
    always_comb begin
        src_bits = '0;
        undrv    = 1'b0;
        bad_idx  = oob(g_dst);
        for (int i = 0; i < MAX_FANIN; i++) begin
            if (used[i]) begin
                if (oob(srcs[i])) begin
                    bad_idx = 1'b1;
                end else begin
                    src_bits[i] = drv[srcs[i]] & val[srcs[i]];
                    if (!drv[srcs[i]]) undrv = 1'b1;
                end
            end
        end
    end

    nse_gate_alu u_alu (
        .op      (gate_op_e'(g_op)),
        .nin     (g_nin),
        .src     (src_bits),
        .res     (alu_res),
        .illegal (alu_ill)
    );

    assign fmt   = alu_ill | bad_idx;
    assign multi = !fmt && drv[g_dst];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_LOAD;
            S_LOAD:         state_nx = S_RUN;
            S_RUN:          if (accept && g_last) state_nx = S_DONE;
        endcase
    end

    always_comb begin
        g_ready = (state == S_RUN);
        done    = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val       <= '0;
            drv       <= '0;
            gate_cnt  <= '0;
            err_multi <= 1'b0;
            err_undrv <= 1'b0;
            err_fmt   <= 1'b0;
        end else if (state == S_LOAD) begin
            val       <= {{(NUM_SIG-NUM_PI){1'b0}}, pi_vec};
            drv       <= {{(NUM_SIG-NUM_PI){1'b0}}, {NUM_PI{1'b1}}};
            gate_cnt  <= '0;
            err_multi <= 1'b0;
            err_undrv <= 1'b0;
            err_fmt   <= 1'b0;
        end else if (state == S_RUN && accept) begin
            if (!(&gate_cnt)) gate_cnt <= gate_cnt + 1'b1;
            if (undrv) err_undrv <= 1'b1;
            if (multi) err_multi <= 1'b1;
            if (fmt) begin
                err_fmt <= 1'b1;
            end else begin
                val[g_dst] <= alu_res;
                drv[g_dst] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_netlist_stream_eval.sv
// Table-driven bench for netlist_stream_eval with an observation scoreboard.
// Expectations for opcodes 6/7 follow NSE_XOR_EN.
module tb_netlist_stream_eval;

    localparam logic [2:0] AND_ = 3'd0, OR_ = 3'd1, NAND_ = 3'd2, NOR_ = 3'd3;
    localparam logic [2:0] NOT_ = 3'd4, BUF_ = 3'd5, XOR_ = 3'd6;
    localparam int NV = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] pi_vec = '0;
    logic       g_valid = 1'b0;
    logic       g_ready;
    logic [2:0] g_op = '0;
    logic [1:0] g_nin = '0;
    logic [5:0] g_dst = '0, g_src0 = '0, g_src1 = '0, g_src2 = '0;
    logic       g_last = 1'b0;
    logic [5:0] o_idx = '0;
    logic       o_val, done, err_multi, err_undrv, err_fmt;
    logic [7:0] gate_cnt;

    always #5 clk = ~clk;

    netlist_stream_eval dut (
        .clk(clk), .rst(rst), .start(start), .pi_vec(pi_vec),
        .g_valid(g_valid), .g_ready(g_ready), .g_op(g_op), .g_nin(g_nin),
        .g_dst(g_dst), .g_src0(g_src0), .g_src1(g_src1), .g_src2(g_src2),
        .g_last(g_last), .o_idx(o_idx), .o_val(o_val), .done(done),
        .gate_cnt(gate_cnt), .err_multi(err_multi), .err_undrv(err_undrv),
        .err_fmt(err_fmt)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] nin;
        logic [5:0] dst, s0, s1, s2;
    } gate_t;

    typedef struct packed {
        logic [9:0]      pi;
        logic [2:0]      ng;
        gate_t [3:0]     g;
        logic [2:0]      nobs;
        logic [3:0][5:0] oidx;
        logic [3:0]      oval;
        logic            emulti, eundrv, efmt;
        logic [7:0]      ecnt;
    } vec_t;

    typedef struct packed {
        logic [5:0] idx;
        logic       val;
    } obs_t;

    vec_t vecs [NV];
    obs_t sb [$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic gate_t mk(input logic [2:0] op, input int nin, d, a, b, c);
        gate_t r;
        r.op = op; r.nin = 2'(nin); r.dst = 6'(d);
        r.s0 = 6'(a); r.s1 = 6'(b); r.s2 = 6'(c);
        return r;
    endfunction

    function automatic void add_g(input int i, input gate_t g);
        vecs[i].g[vecs[i].ng] = g;
        vecs[i].ng++;
    endfunction

    function automatic void add_o(input int i, input int idx, input bit v);
        vecs[i].oidx[vecs[i].nobs] = 6'(idx);
        vecs[i].oval[vecs[i].nobs] = v;
        vecs[i].nobs++;
    endfunction

    function automatic void set_e(input int i, input bit m, u, f, input int cnt);
        vecs[i].emulti = m; vecs[i].eundrv = u;
        vecs[i].efmt = f;   vecs[i].ecnt = 8'(cnt);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
    endtask

    task automatic send(input gate_t g, input bit last, output int stall);
        g_valid = 1'b1;
        g_op = g.op; g_nin = g.nin; g_dst = g.dst;
        g_src0 = g.s0; g_src1 = g.s1; g_src2 = g.s2;
        g_last = last;
        stall = 0;
        while (!g_ready && stall < 20) begin
            step;
            stall++;
        end
        step;
    endtask

    task automatic wait_done(input string nm);
        int w = 0;
        while (!done && w < 20) begin
            step;
            w++;
        end
        chk(nm, done, 1);
    endtask

    initial begin
        int stalls, s;
        obs_t o;
        bit xf;
`ifdef NSE_XOR_EN
        xf = 1'b0;
`else
        xf = 1'b1;
`endif
        for (int i = 0; i < NV; i++) vecs[i] = '0;
        vecs[0].pi = 10'b11;
        add_g(0, mk(AND_, 2, 10, 0, 1, 0));
        add_o(0, 10, 1); set_e(0, 0, 0, 0, 1);
        vecs[1].pi = 10'b0;
        add_g(1, mk(OR_, 2, 10, 0, 1, 0));
        add_g(1, mk(NOT_, 1, 11, 10, 0, 0));
        add_g(1, mk(NOR_, 2, 12, 10, 11, 0));
        add_o(1, 10, 0); add_o(1, 11, 1); add_o(1, 12, 0); set_e(1, 0, 0, 0, 3);
        vecs[2].pi = 10'b0000001011;
        add_g(2, mk(AND_, 2, 19, 0, 3, 0));
        add_g(2, mk(AND_, 2, 19, 1, 4, 0));
        add_o(2, 19, 0); set_e(2, 1, 0, 0, 2);
        vecs[3].pi = 10'h3FF;
        add_g(3, mk(AND_, 2, 16, 0, 50, 0));
        add_o(3, 16, 0); set_e(3, 0, 1, 0, 1);
        vecs[4].pi = 10'b011;
        add_g(4, mk(XOR_, 3, 10, 0, 1, 2));
        add_o(4, 10, 0); set_e(4, 0, 0, xf, 1);
        vecs[5].pi = 10'b0000000111;
        add_g(5, mk(NAND_, 3, 10, 0, 1, 2));
        add_g(5, mk(NOR_, 3, 11, 3, 4, 5));
        add_g(5, mk(BUF_, 1, 12, 0, 0, 0));
        add_g(5, mk(AND_, 2, 13, 0, 1, 50));
        add_o(5, 10, 0); add_o(5, 11, 1); add_o(5, 12, 1); add_o(5, 13, 1);
        set_e(5, 0, 0, 0, 4);
        vecs[6].pi = 10'b0;
        add_g(6, mk(NOT_, 2, 10, 0, 1, 0));
        add_g(6, mk(AND_, 0, 11, 0, 0, 0));
        add_o(6, 10, 0); add_o(6, 11, 0); set_e(6, 0, 0, 1, 2);
        vecs[7].pi = 10'b1;
        add_g(7, mk(BUF_, 1, 3, 0, 0, 0));
        add_o(7, 3, 1); set_e(7, 1, 0, 0, 1);
        vecs[8].pi = 10'b11;
        add_g(8, mk(OR_, 2, 10, 0, 1, 0));
        add_g(8, mk(NOT_, 3, 11, 10, 0, 0));
        add_o(8, 10, 1); add_o(8, 11, 0); set_e(8, 0, 0, 1, 2);

        step; step;
        chk("reset g_ready", g_ready, 0);
        chk("reset done", done, 0);
        chk("reset cnt", gate_cnt, 0);
        chk("reset errs", {err_multi, err_undrv, err_fmt}, 0);
        chk("reset o_val", o_val, 0);
        rst = 1'b0;
        step;

        for (int i = 0; i < NV; i++) begin
            pi_vec = vecs[i].pi;
            for (int k = 0; k < 4; k++)
                if (k < int'(vecs[i].nobs))
                    sb.push_back({vecs[i].oidx[k], vecs[i].oval[k]});
            do_start;
            stalls = 0;
            for (int k = 0; k < int'(vecs[i].ng); k++) begin
                send(vecs[i].g[k], k == int'(vecs[i].ng) - 1, s);
                stalls += s;
            end
            g_valid = 1'b0; g_last = 1'b0;
            wait_done($sformatf("v%0d done", i));
            chk($sformatf("v%0d stalls", i), stalls, 0);
            chk($sformatf("v%0d cnt", i), gate_cnt, vecs[i].ecnt);
            chk($sformatf("v%0d multi", i), err_multi, vecs[i].emulti);
            chk($sformatf("v%0d undrv", i), err_undrv, vecs[i].eundrv);
            chk($sformatf("v%0d fmt", i), err_fmt, vecs[i].efmt);
            while (sb.size() > 0) begin
                o = sb.pop_front();
                o_idx = o.idx;
                #1;
                chk($sformatf("v%0d slot%0d", i, o.idx), o_val, o.val);
            end
        end

        // start during RUN must not restart the run
        pi_vec = 10'b11;
        do_start;
        start = 1'b1;
        send(mk(AND_, 2, 10, 0, 1, 0), 1'b0, s);
        send(mk(NAND_, 2, 11, 0, 1, 0), 1'b1, s);
        start = 1'b0; g_valid = 1'b0; g_last = 1'b0;
        wait_done("start-in-run done");
        chk("start-in-run cnt", gate_cnt, 2);
        o_idx = 6'd10; #1;
        chk("start-in-run slot10", o_val, 1);

        // reset mid-run
        pi_vec = 10'h3FF;
        do_start;
        send(mk(AND_, 2, 10, 0, 1, 0), 1'b0, s);
        send(mk(AND_, 2, 10, 0, 1, 0), 1'b0, s);
        g_valid = 1'b0;
        rst = 1'b1;
        step;
        o_idx = 6'd0; #1;
        chk("midrst g_ready", g_ready, 0);
        chk("midrst done", done, 0);
        chk("midrst cnt", gate_cnt, 0);
        chk("midrst errs", {err_multi, err_undrv, err_fmt}, 0);
        chk("midrst o_val", o_val, 0);
        rst = 1'b0;
        step;

        // counter saturation
        do_start;
        for (int k = 0; k < 256; k++) send(mk(AND_, 2, 10, 0, 1, 0), k == 255, s);
        g_valid = 1'b0; g_last = 1'b0;
        wait_done("sat done");
        chk("sat cnt", gate_cnt, 255);
        chk("sat multi", err_multi, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
